// File: rtl/bridge_bus_arbiter_pkg.sv
// Shared encodings and defaults for the two-master bridge arbiter.
package bridge_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN0     = 2'd1,
        OWN1     = 2'd2
    } owner_t;

    localparam int unsigned DEFAULT_MAX_BURST = 4;
    localparam int unsigned DEFAULT_CNT_W     = 4;

endpackage

// File: rtl/arb_burst_counter.sv
// Saturating count of consecutive grants to the current bus owner.
module arb_burst_counter #(
    parameter int unsigned MAX = 4,
    parameter int unsigned W   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load1) begin
            count <= W'(1);
        end else if (inc && (count < W'(MAX))) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/bridge_bus_arbiter.sv
// Two-master arbiter for the system bridge: burst-limited ownership with
// round-robin tie break, zero-latency combinational grant and mux.
module bridge_bus_arbiter
    import bridge_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST,
    parameter int unsigned CNT_W     = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [31:0] m0_wdata,
    output logic        m0_stall,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  gnt
);

    owner_t           ownerQ;
    logic             lastQ;
    logic [CNT_W-1:0] burstCnt;
    logic [1:0]       gntC;
    owner_t           grantOwn;
    logic             burstDone;

    assign burstDone = (burstCnt >= CNT_W'(MAX_BURST));

    // Grant decision: single requester wins outright, contention honours burst limit.
    always_comb begin
        gntC = 2'b00;
        if (m0_req && m1_req) begin
            case (ownerQ)
                OWN0:    gntC = burstDone ? 2'b10 : 2'b01;
                OWN1:    gntC = burstDone ? 2'b01 : 2'b10;
                default: gntC = lastQ ? 2'b01 : 2'b10;
            endcase
        end else if (m0_req) begin
            gntC = 2'b01;
        end else if (m1_req) begin
            gntC = 2'b10;
        end
    end

    always_comb begin
        grantOwn = OWN_IDLE;
        if (gntC[0]) begin
            grantOwn = OWN0;
        end else if (gntC[1]) begin
            grantOwn = OWN1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ownerQ <= OWN_IDLE;
            lastQ  <= 1'b1;
        end else begin
            ownerQ <= grantOwn;
            if (gntC != 2'b00) begin
                lastQ <= gntC[1];
            end
        end
    end

    arb_burst_counter #(
        .MAX (MAX_BURST),
        .W   (CNT_W)
    ) uBurstCounter (
        .clk   (clk),
        .reset (reset),
        .clear (gntC == 2'b00),
        .load1 ((gntC != 2'b00) && (grantOwn != ownerQ)),
        .inc   ((gntC != 2'b00) && (grantOwn == ownerQ)),
        .count (burstCnt)
    );

    // Outputs are held quiet while reset is asserted.
    always_comb begin
        gnt       = reset ? 2'b00 : gntC;
        bus_addr  = 32'h0;
        bus_wdata = 32'h0;
        bus_we    = 1'b0;
        if (gnt[0]) begin
            bus_addr  = m0_addr;
            bus_wdata = m0_wdata;
            bus_we    = m0_we;
        end else if (gnt[1]) begin
            bus_addr  = m1_addr;
            bus_wdata = m1_wdata;
            bus_we    = m1_we;
        end
        m0_stall = ~reset & m0_req & ~gnt[0];
        m1_ack   = m1_req & gnt[1];
    end

    assign m0_rdata = bus_rdata;
    assign m1_rdata = bus_rdata;

endmodule

// File: tb/tb_bridge_bus_arbiter.sv
// Directed self-checking bench for bridge_bus_arbiter (MAX_BURST=4).
module tb_bridge_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;
    logic        m0_stall, m1_ack, bus_we;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
    logic [1:0]  gnt;

    int nChecks = 0;
    int nFails  = 0;

    bridge_bus_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_we     (m0_we),
        .m0_wdata  (m0_wdata),
        .m0_stall  (m0_stall),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_we     (m1_we),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .gnt       (gnt)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge so new inputs apply to a fresh cycle.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
        nextCycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
        m0_we = 1'b1; m1_we = 1'b1;
        m0_addr = 32'hAAAA_0000; m1_addr = 32'hBBBB_0000;
        m0_wdata = 32'h1111_1111; m1_wdata = 32'h2222_2222;
        @(negedge clk);
        nChecks++; if (gnt !== 2'b00) begin nFails++; $display("FAIL reset_gnt got %b want 00", gnt); end
        nChecks++; if (bus_we !== 1'b0) begin nFails++; $display("FAIL reset_we got %b want 0", bus_we); end
        nChecks++; if (m0_stall !== 1'b0 || m1_ack !== 1'b0) begin nFails++; $display("FAIL reset_stall_ack got %b%b want 00", m0_stall, m1_ack); end
        nChecks++; if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin nFails++; $display("FAIL reset_bus got %h/%h want 0/0", bus_addr, bus_wdata); end
        nextCycle();
        reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        nChecks++; if (gnt !== 2'b00 || bus_addr !== 32'h0 || bus_we !== 1'b0) begin nFails++; $display("FAIL idle_outputs got gnt=%b addr=%h we=%b want 00/0/0", gnt, bus_addr, bus_we); end
        nextCycle();
    endtask

    task automatic test_single_m0();
        applyReset();
        m0_req = 1'b1; m0_addr = 32'h0000_1000; m0_we = 1'b1; m0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        nChecks++; if (gnt !== 2'b01) begin nFails++; $display("FAIL m0_gnt got %b want 01", gnt); end
        nChecks++; if (bus_we !== 1'b1 || bus_addr !== 32'h1000) begin nFails++; $display("FAIL m0_bus got we=%b addr=%h want 1/00001000", bus_we, bus_addr); end
        nChecks++; if (bus_wdata !== 32'hDEAD_BEEF || m0_stall !== 1'b0) begin nFails++; $display("FAIL m0_wdata got %h stall=%b want deadbeef/0", bus_wdata, m0_stall); end
        nextCycle();
        m0_req = 1'b0;
    endtask

    task automatic test_contention();
        logic [1:0] expGnt;
        applyReset();
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b1;
        m0_addr = 32'h0000_2000; m1_addr = 32'h0000_3000;
        for (int i = 0; i < 12; i++) begin
            expGnt = (i >= 4 && i < 8) ? 2'b10 : 2'b01;
            @(negedge clk);
            nChecks++; if (gnt !== expGnt) begin nFails++; $display("FAIL contention_gnt[%0d] got %b want %b", i, gnt, expGnt); end
            nChecks++; if (m0_stall !== expGnt[1] || m1_ack !== expGnt[1]) begin nFails++; $display("FAIL contention_stall_ack[%0d] got %b%b want %b%b", i, m0_stall, m1_ack, expGnt[1], expGnt[1]); end
            nChecks++; if (bus_addr !== (expGnt[1] ? 32'h3000 : 32'h2000) || bus_we !== expGnt[1]) begin nFails++; $display("FAIL contention_bus[%0d] got %h/%b", i, bus_addr, bus_we); end
            nextCycle();
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_m1_then_m0();
        applyReset();
        m1_req = 1'b1; m1_addr = 32'h0000_7F00; m1_we = 1'b1; m1_wdata = 32'h0000_0055;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nChecks++; if (gnt !== 2'b10 || m1_ack !== 1'b1) begin nFails++; $display("FAIL m1_alone[%0d] got gnt=%b ack=%b want 10/1", i, gnt, m1_ack); end
            nChecks++; if (bus_we !== 1'b1 || bus_addr !== 32'h7F00 || bus_wdata !== 32'h55) begin nFails++; $display("FAIL m1_alone_bus[%0d] got %b/%h/%h", i, bus_we, bus_addr, bus_wdata); end
            nextCycle();
        end
        m0_req = 1'b1; m0_addr = 32'h0000_4000; m0_we = 1'b0;
        @(negedge clk);
        nChecks++; if (gnt !== 2'b10 || m0_stall !== 1'b1) begin nFails++; $display("FAIL m1_keeps got gnt=%b stall=%b want 10/1", gnt, m0_stall); end
        nextCycle();
        @(negedge clk);
        nChecks++; if (gnt !== 2'b01 || m0_stall !== 1'b0 || m1_ack !== 1'b0) begin nFails++; $display("FAIL m0_takes got gnt=%b stall=%b ack=%b want 01/0/0", gnt, m0_stall, m1_ack); end
        nextCycle();
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_idle_gap();
        applyReset();
        m0_req = 1'b1;
        nextCycle();
        nextCycle();
        m0_req = 1'b0;
        @(negedge clk);
        nChecks++; if (gnt !== 2'b00) begin nFails++; $display("FAIL gap_gnt got %b want 00", gnt); end
        nextCycle();
        m0_req = 1'b1; m1_req = 1'b1;
        @(negedge clk);
        nChecks++; if (gnt !== 2'b10) begin nFails++; $display("FAIL gap_tie got %b want 10", gnt); end
        nextCycle();
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        applyReset();
        m1_req = 1'b1; m1_we = 1'b1;
        nextCycle();
        nextCycle();
        reset = 1'b1; m0_req = 1'b1; m0_we = 1'b1;
        @(negedge clk);
        nChecks++; if (gnt !== 2'b00 || bus_we !== 1'b0 || m0_stall !== 1'b0) begin nFails++; $display("FAIL midreset got gnt=%b we=%b stall=%b want 00/0/0", gnt, bus_we, m0_stall); end
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        nChecks++; if (gnt !== 2'b01) begin nFails++; $display("FAIL after_reset_tie got %b want 01", gnt); end
        nextCycle();
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_read_path();
        applyReset();
        m1_req = 1'b1; m1_we = 1'b0;
        nextCycle();
        m0_req = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        nChecks++; if (gnt !== 2'b10 || m0_stall !== 1'b1) begin nFails++; $display("FAIL read_gnt got %b stall=%b want 10/1", gnt, m0_stall); end
        nChecks++; if (m1_rdata !== 32'h1234_5678 || m0_rdata !== 32'h1234_5678) begin nFails++; $display("FAIL read_data got %h/%h want 12345678", m0_rdata, m1_rdata); end
        nextCycle();
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        bus_rdata = '0;
        #1;
        test_reset();
        test_single_m0();
        test_contention();
        test_m1_then_m0();
        test_idle_gap();
        test_reset_mid_burst();
        test_read_path();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
